mallet_ctrl: RTL and testbench
==============================

Name: mallet_ctrl

Overview:
Per-player mallet controller that sits directly upstream of the puck mover and drives one ballN_x/ballN_y pair. Takes raw push-buttons, synchronises and debounces them, and moves the mallet once per cursor tick, with hold-to-accelerate. Clamps the mallet to that player's half of the rink and re-homes/freezes it after any goal. Two instances per design: left player and right player.

Parameters:
X_MIN, 234, left clamp bound (inclusive)
X_MAX, 464, right clamp bound (inclusive); right-player instance uses 464/694
Y_MIN, 111, top clamp bound (inclusive)
Y_MAX, 431, bottom clamp bound (inclusive)
HOME_X, 349, x position after reset/goal
HOME_Y, 271, y position after reset/goal
DEBOUNCE_CYCLES, 250000, consecutive stable clk cycles needed to accept a button change
ACCEL_TICKS, 8, consecutive held ticks per step increment
MAX_STEP, 4, step saturation value (1..15)
FREEZE_TICKS, 30, ticks the mallet stays frozen at home after a goal

Ports:
clk  in  1  system clock
clr  in  1  asynchronous, active-low reset
btn_up  in  1  raw button, async, active-high
btn_down  in  1  raw button, async, active-high
btn_left  in  1  raw button, async, active-high
btn_right  in  1  raw button, async, active-high
clk_cursor  in  1  movement tick level, synchronous to clk; rising edge = one tick
goal  in  1  one-cycle pulse, collide1|collide2 from mover
ball_x  out  10  mallet x, registered
ball_y  out  10  mallet y, registered
moving  out  1  high while state is MOVE
frozen  out  1  high while state is FROZEN

Behaviour:
- Reset (clr=0, async): ball_x=HOME_X, ball_y=HOME_Y, state=IDLE, step=1, accel count=0, freeze count=0, debounced buttons=0, tick-edge register=0, moving=0, frozen=0.
- Sync: each button goes through a 2-FF synchroniser. Debounced level changes only after the synchronised value differs from the debounced value for DEBOUNCE_CYCLES consecutive clk cycles. Any mismatch-free cycle clears the counter.
- Tick: tick=1 on a clk edge where clk_cursor=1 and the internal previous-sample register=0. The register updates every cycle. Position updates on that same edge and is visible on outputs the next cycle.
- Direction per axis: dx=+1 if right only, -1 if left only, 0 if neither or both. dy is the same with down=+ and up=-.
- States:
  - IDLE: if tick and (dx!=0 or dy!=0), apply the move and go to MOVE.
  - MOVE: each tick, if dx or dy is nonzero, apply the move. If both are zero, go to IDLE and set step=1, accel count=0.
  - FROZEN: buttons are ignored. freeze count increments per tick. After FREEZE_TICKS ticks, go to IDLE with step=1.
- Move: new = pos + dir*step, computed in 11-bit signed, then clamped to [MIN, MAX] per axis. Axes are independent, so a diagonal move is allowed.
- Acceleration: in MOVE, accel count increments on each moving tick. On reaching ACCEL_TICKS, step = min(step+1, MAX_STEP) and the count clears.
- Goal: from any state, goal=1 means next cycle pos=HOME, state=FROZEN, freeze count=0, step=1. A goal during FROZEN restarts the freeze. Goal has priority over a coincident tick move.
- Clamping is saturating; no wrap-around at 0 or 1023.
- Outputs: moving=(state==MOVE), frozen=(state==FROZEN), both registered.

Test Plan:
- Reset mid-move (ball_x=400), assert clr=0 async between clk edges -> ball_x=349, ball_y=271 immediately, moving=0.
- DEBOUNCE_CYCLES=4: btn_right pulses high for 3 cycles -> no change. Held for 4+ cycles, then one tick -> ball_x 349->350, moving=1.
- ACCEL_TICKS=2, hold btn_right for 10 ticks from 349 -> x sequence 350,351,353,355,358,361,365,369,373,377; step saturates at 4.
- Hold btn_up from y=113 with step 4 -> y=111 and stays at 111. Left/right clamping checked the same way at X_MIN and X_MAX.
- btn_left and btn_right held together with btn_down -> x unchanged, y increments.
- goal pulse coincident with a tick while at (400,200) -> (349,271), frozen=1. Buttons are ignored for 30 ticks. A second goal at tick 10 extends the freeze to 40 total ticks, then IDLE.

Source files
------------

// File: rtl/mallet_ctrl.sv
// Per-player mallet controller: synchronises and debounces four push-buttons, steps the
// mallet once per cursor tick with hold-to-accelerate, clamps to the player's half, freezes after goals.
module mallet_ctrl #(
    parameter int X_MIN           = 234,
    parameter int X_MAX           = 464,
    parameter int Y_MIN           = 111,
    parameter int Y_MAX           = 431,
    parameter int HOME_X          = 349,
    parameter int HOME_Y          = 271,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int ACCEL_TICKS     = 8,
    parameter int MAX_STEP        = 4,
    parameter int FREEZE_TICKS    = 30
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       clk_cursor,
    input  logic       goal,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       moving,
    output logic       frozen
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] MOVE   = 2'd1;
    localparam logic [1:0] FROZEN = 2'd2;

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int AW = $clog2(ACCEL_TICKS + 1);
    localparam int FW = $clog2(FREEZE_TICKS + 1);

    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW-1:0] ACC_LAST = AW'(ACCEL_TICKS - 1);
    localparam logic [FW-1:0] FRZ_LAST = FW'(FREEZE_TICKS - 1);
    localparam logic [3:0]    STEP_MAX = 4'(MAX_STEP);
    localparam logic [9:0]    HX       = 10'(HOME_X);
    localparam logic [9:0]    HY       = 10'(HOME_Y);

    localparam logic signed [11:0] X_LO = 12'(X_MIN);
    localparam logic signed [11:0] X_HI = 12'(X_MAX);
    localparam logic signed [11:0] Y_LO = 12'(Y_MIN);
    localparam logic signed [11:0] Y_HI = 12'(Y_MAX);

    // Button bit order throughout: {up, down, left, right}
    logic [3:0] raw;
    logic [3:0] sync1_q, sync2_q, deb_q, deb_d;
    logic [DW-1:0] deb_cnt_q [4];
    logic [DW-1:0] deb_cnt_d [4];

    logic [1:0]    state_q, state_d;
    logic [9:0]    ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic [3:0]    step_q, step_d;
    logic [AW-1:0] accel_q, accel_d;
    logic [FW-1:0] frz_q, frz_d;
    logic          cur_prev_q, moving_q, frozen_q;

    logic tick, right_only, left_only, down_only, up_only, any_dir;
    logic signed [11:0] step_s, x_sum, y_sum;
    logic [9:0] x_mv, y_mv;

    assign raw = {btn_up, btn_down, btn_left, btn_right};

    // A change is accepted only after DEBOUNCE_CYCLES consecutive mismatching cycles.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 4; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) deb_d[i] = sync2_q[i];
                else deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
            end
        end
    end

    function automatic logic [9:0] clamp(input logic signed [11:0] v,
                                         input logic signed [11:0] lo,
                                         input logic signed [11:0] hi);
        logic signed [11:0] r;
        r = v;
        if (v < lo) r = lo;
        if (v > hi) r = hi;
        return r[9:0];
    endfunction

    assign tick       = clk_cursor & ~cur_prev_q;
    assign right_only = deb_q[0] & ~deb_q[1];
    assign left_only  = deb_q[1] & ~deb_q[0];
    assign down_only  = deb_q[2] & ~deb_q[3];
    assign up_only    = deb_q[3] & ~deb_q[2];
    assign any_dir    = right_only | left_only | down_only | up_only;

    assign step_s = signed'({8'd0, step_q});
    assign x_sum  = signed'({2'b00, ball_x_q}) + (right_only ? step_s : (left_only ? -step_s : 12'sd0));
    assign y_sum  = signed'({2'b00, ball_y_q}) + (down_only  ? step_s : (up_only   ? -step_s : 12'sd0));
    assign x_mv   = clamp(x_sum, X_LO, X_HI);
    assign y_mv   = clamp(y_sum, Y_LO, Y_HI);

    always_comb begin
        state_d  = state_q;
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        step_d   = step_q;
        accel_d  = accel_q;
        frz_d    = frz_q;
        if (goal) begin
            // A goal wins over any tick move on the same edge.
            state_d  = FROZEN;
            ball_x_d = HX;
            ball_y_d = HY;
            step_d   = 4'd1;
            accel_d  = '0;
            frz_d    = '0;
        end else if (tick) begin
            case (state_q)
                IDLE, MOVE: begin
                    if (any_dir) begin
                        state_d  = MOVE;
                        ball_x_d = x_mv;
                        ball_y_d = y_mv;
                        if (accel_q == ACC_LAST) begin
                            accel_d = '0;
                            if (step_q < STEP_MAX) step_d = step_q + 4'd1;
                        end else begin
                            accel_d = accel_q + AW'(1);
                        end
                    end else begin
                        state_d = IDLE;
                        step_d  = 4'd1;
                        accel_d = '0;
                    end
                end
                FROZEN: begin
                    if (frz_q == FRZ_LAST) begin
                        state_d = IDLE;
                        frz_d   = '0;
                        step_d  = 4'd1;
                        accel_d = '0;
                    end else begin
                        frz_d = frz_q + FW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
            cur_prev_q <= 1'b0;
            state_q    <= IDLE;
            ball_x_q   <= HX;
            ball_y_q   <= HY;
            step_q     <= 4'd1;
            accel_q    <= '0;
            frz_q      <= '0;
            moving_q   <= 1'b0;
            frozen_q   <= 1'b0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            for (int i = 0; i < 4; i++) deb_cnt_q[i] <= deb_cnt_d[i];
            cur_prev_q <= clk_cursor;
            state_q    <= state_d;
            ball_x_q   <= ball_x_d;
            ball_y_q   <= ball_y_d;
            step_q     <= step_d;
            accel_q    <= accel_d;
            frz_q      <= frz_d;
            moving_q   <= (state_d == MOVE);
            frozen_q   <= (state_d == FROZEN);
        end
    end

    assign ball_x = ball_x_q;
    assign ball_y = ball_y_q;
    assign moving = moving_q;
    assign frozen = frozen_q;
endmodule

// File: tb/tb_mallet_ctrl.sv
// Directed bench for mallet_ctrl: a vector table for stepping, acceleration and clamping,
// plus hand sequences for reset, debounce and goal freeze.
module tb_mallet_ctrl;
  logic       clk = 1'b0;
  logic       clr;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic       clk_cursor, goal;
  logic [9:0] ball_x, ball_y;
  logic       moving, frozen;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [3:0] B_NONE = 4'b0000;
  localparam logic [3:0] B_R    = 4'b0001;
  localparam logic [3:0] B_L    = 4'b0010;
  localparam logic [3:0] B_D    = 4'b0100;
  localparam logic [3:0] B_U    = 4'b1000;

  typedef struct {
    logic [3:0] btn;
    int         ticks;
    logic [9:0] x;
    logic [9:0] y;
    logic       mv;
    logic       fz;
  } vec_t;

  vec_t vecs[$];

  mallet_ctrl #(
    .X_MIN(234), .X_MAX(464), .Y_MIN(111), .Y_MAX(431),
    .HOME_X(349), .HOME_Y(271),
    .DEBOUNCE_CYCLES(4), .ACCEL_TICKS(2), .MAX_STEP(4), .FREEZE_TICKS(30)
  ) dut (
    .clk(clk), .clr(clr),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .clk_cursor(clk_cursor), .goal(goal),
    .ball_x(ball_x), .ball_y(ball_y), .moving(moving), .frozen(frozen)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input int x, input int y, input logic mv, input logic fz);
    check({name, ".x"}, int'(ball_x), x);
    check({name, ".y"}, int'(ball_y), y);
    check({name, ".moving"}, int'(moving), int'(mv));
    check({name, ".frozen"}, int'(frozen), int'(fz));
  endtask

  // Drive raw buttons and let the synchroniser plus debounce settle.
  task automatic set_buttons(input logic [3:0] b);
    @(negedge clk);
    {btn_up, btn_down, btn_left, btn_right} = b;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_tick(input logic with_goal);
    @(negedge clk);
    clk_cursor = 1'b1;
    goal       = with_goal;
    @(negedge clk);
    clk_cursor = 1'b0;
    goal       = 1'b0;
    @(negedge clk);
  endtask

  task automatic add(input logic [3:0] b, input int t, input int x, input int y, input logic mv, input logic fz);
    vec_t v;
    v.btn = b; v.ticks = t; v.x = 10'(x); v.y = 10'(y); v.mv = mv; v.fz = fz;
    vecs.push_back(v);
  endtask

  initial begin
    // Acceleration from home with ACCEL_TICKS=2: steps 1,1,2,2,3,3,4,...
    add(B_R, 1, 350, 271, 1, 0);
    add(B_R, 1, 351, 271, 1, 0);
    add(B_R, 1, 353, 271, 1, 0);
    add(B_R, 1, 355, 271, 1, 0);
    add(B_R, 1, 358, 271, 1, 0);
    add(B_R, 1, 361, 271, 1, 0);
    add(B_R, 1, 365, 271, 1, 0);
    add(B_R, 1, 369, 271, 1, 0);
    add(B_R, 1, 373, 271, 1, 0);
    add(B_R, 1, 377, 271, 1, 0);
    add(B_R, 21, 461, 271, 1, 0);
    add(B_R, 1, 464, 271, 1, 0);
    add(B_R, 1, 464, 271, 1, 0);
    add(B_NONE, 1, 464, 271, 0, 0);
    // Left+right cancel, down still moves.
    add(B_L | B_R | B_D, 1, 464, 272, 1, 0);
    add(B_L | B_R | B_D, 1, 464, 273, 1, 0);
    add(B_NONE, 1, 464, 273, 0, 0);
    add(B_U, 7, 464, 257, 1, 0);
    add(B_U, 36, 464, 113, 1, 0);
    add(B_U, 1, 464, 111, 1, 0);
    add(B_U, 1, 464, 111, 1, 0);
    add(B_NONE, 1, 464, 111, 0, 0);
    add(B_L, 7, 448, 111, 1, 0);
    add(B_L, 53, 236, 111, 1, 0);
    add(B_L, 1, 234, 111, 1, 0);
    add(B_L, 1, 234, 111, 1, 0);
    add(B_NONE, 1, 234, 111, 0, 0);
    add(B_R | B_D, 1, 235, 112, 1, 0);
    add(B_NONE, 1, 235, 112, 0, 0);

    {btn_up, btn_down, btn_left, btn_right} = B_NONE;
    clk_cursor = 1'b0;
    goal       = 1'b0;
    clr        = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset", 349, 271, 0, 0);
    clr = 1'b1;

    // Debounce: a 3-cycle pulse is rejected, a sustained press is accepted.
    @(negedge clk);
    btn_right = 1'b1;
    repeat (3) @(negedge clk);
    btn_right = 1'b0;
    repeat (10) @(negedge clk);
    do_tick(1'b0);
    check_all("short_pulse", 349, 271, 0, 0);
    set_buttons(B_R);
    do_tick(1'b0);
    check_all("debounced_press", 350, 271, 1, 0);
    set_buttons(B_NONE);

    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      set_buttons(vecs[i].btn);
      repeat (vecs[i].ticks) do_tick(1'b0);
      check_all($sformatf("vec%0d", i), int'(vecs[i].x), int'(vecs[i].y), vecs[i].mv, vecs[i].fz);
    end

    // Asynchronous reset mid-move, applied between clock edges.
    set_buttons(B_R);
    repeat (7) do_tick(1'b0);
    check_all("pre_reset", 251, 112, 1, 0);
    @(negedge clk);
    #2 clr = 1'b0;
    #1 check_all("async_reset", 349, 271, 0, 0);
    {btn_up, btn_down, btn_left, btn_right} = B_NONE;
    @(negedge clk);
    clr = 1'b1;

    // Goal freeze, restarted by a second goal on the 10th frozen tick.
    set_buttons(B_R);
    do_tick(1'b0);
    check_all("goal_pre", 350, 271, 1, 0);
    do_tick(1'b1);
    check_all("goal_hit", 349, 271, 0, 1);
    for (int i = 1; i <= 9; i++) begin
      do_tick(1'b0);
      check_all($sformatf("frz_a%0d", i), 349, 271, 0, 1);
    end
    do_tick(1'b1);
    check_all("goal_again", 349, 271, 0, 1);
    for (int i = 1; i <= 29; i++) begin
      do_tick(1'b0);
      check(  $sformatf("frz_b%0d.frozen", i), int'(frozen), 1);
    end
    do_tick(1'b0);
    check_all("unfreeze", 349, 271, 0, 0);
    do_tick(1'b0);
    check_all("post_freeze_move", 350, 271, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
